// File: rtl/hamming_batch_engine.sv
// -----------------------------------------------------------------------------
// hamming_batch_engine
//
// Purpose:
//   Services USB vendor requests that compute Hamming distances. The results
//   are written into the IN buffer, and that buffer is then committed to the
//   host.
//     0x01 SINGLE      : popcount(val[15:8] ^ val[7:0]) written at addr 0, len 1
//     0x02 SET_PATTERN : pattern <= val[WORD_W-1:0], no write / no commit
//     0x03 SWEEP       : byte i = popcount((start + i) ^ pattern), i < MAX_RESULTS
//     other            : sets the sticky err_unknown_req flag
//
// Optional feature (macro HAMMING_MIN_TRACK_EN):
//   A SWEEP also tracks the minimum distance, with the first index winning ties.
//   The minimum is appended at addr MAX_RESULTS and its index[7:0] at
//   addr MAX_RESULTS+1. The commit length becomes MAX_RESULTS+2.
//
// Ports:
//   clk_50            : single clock, rising edge
//   reset             : synchronous active-high reset
//   usb_configured    : device configured; starts are accepted only when high
//   buf_in_ready      : IN buffer free (other clock domain, synchronised here)
//   buf_in_commit_ack : commit acknowledge (other domain, synchronised here)
//   vend_req_act      : vendor request active (other domain, rising edge = start)
//   vend_req_request  : vendor request code
//   vend_req_val      : vendor request wValue
//   buf_in_addr/data/wren     : IN buffer write port
//   buf_in_commit/commit_len  : IN buffer commit handshake
//   busy              : high in every state except IDLE
//   err_unknown_req   : sticky unknown-code flag, cleared only by reset
// -----------------------------------------------------------------------------
module hamming_batch_engine #(
  parameter int WORD_W      = 8,
  parameter int MAX_RESULTS = 64
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        usb_configured,
  input  logic        buf_in_ready,
  input  logic        buf_in_commit_ack,
  input  logic        vend_req_act,
  input  logic [7:0]  vend_req_request,
  input  logic [15:0] vend_req_val,
  output logic [8:0]  buf_in_addr,
  output logic [7:0]  buf_in_data,
  output logic        buf_in_wren,
  output logic        buf_in_commit,
  output logic [9:0]  buf_in_commit_len,
  output logic        busy,
  output logic        err_unknown_req
);

`ifdef HAMMING_MIN_TRACK_EN
  localparam int TOTAL = MAX_RESULTS + 2;
`else
  localparam int TOTAL = MAX_RESULTS;
`endif
  localparam logic [9:0] TOTAL_LEN = 10'(TOTAL);
  localparam logic [9:0] LAST_IDX  = 10'(TOTAL - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_CALC    = 3'd2,
    S_WRITE   = 3'd3,
    S_COMMIT  = 3'd4,
    S_ACK_LOW = 3'd5
  } state_e;

  state_e            state_q;
  logic [1:0]        rdy_sync_q;
  logic [1:0]        ack_sync_q;
  logic [1:0]        act_sync_q;
  logic              act_prev_q;
  logic [7:0]        code_q;
  logic [15:0]       val_q;
  logic [WORD_W-1:0] pattern_q;
  logic [WORD_W-1:0] cand_q;
  logic [9:0]        idx_q;     // index of the next write to be registered
  logic              single_q;
  logic [8:0]        addr_q;
  logic [7:0]        data_q;
  logic              wren_q;
  logic              commit_q;
  logic [9:0]        len_q;
  logic              busy_q;
  logic              err_q;
`ifdef HAMMING_MIN_TRACK_EN
  logic [4:0]        min_q;
  logic [7:0]        min_idx_q;
`endif

  logic              start_d;
  logic [15:0]       operand_d;
  logic [4:0]        pop_d;
  logic [7:0]        wdata_d;
  logic [9:0]        last_idx_d;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  // Start qualification: a synchronised rising edge of vend_req_act while the device is ready.
  assign start_d = act_sync_q[1] & ~act_prev_q & usb_configured & rdy_sync_q[1];

  // Operand of the distance computed this cycle; SINGLE ignores the pattern.
  always_comb begin
    operand_d = 16'd0;
    if (single_q) begin
      operand_d = {8'd0, val_q[15:8] ^ val_q[7:0]};
    end else begin
      operand_d[WORD_W-1:0] = cand_q ^ pattern_q;
    end
  end

  assign pop_d      = popcount16(operand_d);
  assign last_idx_d = single_q ? 10'd0 : LAST_IDX;

  // Byte written next; with min tracking, the two trailer slots carry min and its index.
  always_comb begin
    wdata_d = {3'b000, pop_d};
`ifdef HAMMING_MIN_TRACK_EN
    if (!single_q && (idx_q == 10'(MAX_RESULTS))) begin
      wdata_d = {3'b000, min_q};
    end else if (!single_q && (idx_q == 10'(MAX_RESULTS + 1))) begin
      wdata_d = min_idx_q;
    end else begin
      wdata_d = {3'b000, pop_d};
    end
`endif
  end

  // Control FSM: synchronisers, request sequencing and all registered outputs.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rdy_sync_q <= 2'b00;
      ack_sync_q <= 2'b00;
      act_sync_q <= 2'b00;
      act_prev_q <= 1'b0;
      code_q     <= 8'd0;
      val_q      <= 16'd0;
      pattern_q  <= '0;
      cand_q     <= '0;
      idx_q      <= 10'd0;
      single_q   <= 1'b0;
      addr_q     <= 9'd0;
      data_q     <= 8'd0;
      wren_q     <= 1'b0;
      commit_q   <= 1'b0;
      len_q      <= 10'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef HAMMING_MIN_TRACK_EN
      min_q      <= 5'd0;
      min_idx_q  <= 8'd0;
`endif
    end else begin
      rdy_sync_q <= {rdy_sync_q[0], buf_in_ready};
      ack_sync_q <= {ack_sync_q[0], buf_in_commit_ack};
      act_sync_q <= {act_sync_q[0], vend_req_act};
      // The edge detector runs in every state, so edges seen while busy are dropped.
      act_prev_q <= act_sync_q[1];

      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            code_q  <= vend_req_request;
            val_q   <= vend_req_val;
            busy_q  <= 1'b1;
            state_q <= S_DECODE;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_DECODE: begin
          case (code_q)
            8'h01: begin
              single_q <= 1'b1;
              idx_q    <= 10'd0;
              state_q  <= S_CALC;
            end
            8'h02: begin
              pattern_q <= val_q[WORD_W-1:0];
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end
            8'h03: begin
              single_q <= 1'b0;
              cand_q   <= val_q[WORD_W-1:0];
              idx_q    <= 10'd0;
              state_q  <= S_CALC;
            end
            default: begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          endcase
        end

        // CALC registers write 0; each WRITE cycle presents one write and registers the next.
        S_CALC, S_WRITE: begin
          if (idx_q <= last_idx_d) begin
            wren_q  <= 1'b1;
            addr_q  <= idx_q[8:0];
            data_q  <= wdata_d;
            idx_q   <= idx_q + 10'd1;
            cand_q  <= cand_q + {{(WORD_W-1){1'b0}}, 1'b1};  // wraps mod 2^WORD_W
`ifdef HAMMING_MIN_TRACK_EN
            if (!single_q && (idx_q < 10'(MAX_RESULTS)) &&
                ((idx_q == 10'd0) || (pop_d < min_q))) begin
              min_q     <= pop_d;
              min_idx_q <= idx_q[7:0];
            end
`endif
            state_q <= S_WRITE;
          end else begin
            wren_q   <= 1'b0;
            addr_q   <= 9'd0;
            data_q   <= 8'd0;
            commit_q <= 1'b1;
            len_q    <= single_q ? 10'd1 : TOTAL_LEN;
            state_q  <= S_COMMIT;
          end
        end

        S_COMMIT: begin
          if (ack_sync_q[1]) begin
            commit_q <= 1'b0;
            len_q    <= 10'd0;
            state_q  <= S_ACK_LOW;
          end else begin
            state_q  <= S_COMMIT;
          end
        end

        S_ACK_LOW: begin
          if (!ack_sync_q[1]) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_ACK_LOW;
          end
        end

        default: begin
          wren_q   <= 1'b0;
          commit_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign buf_in_addr       = addr_q;
  assign buf_in_data       = data_q;
  assign buf_in_wren       = wren_q;
  assign buf_in_commit     = commit_q;
  assign buf_in_commit_len = len_q;
  assign busy              = busy_q;
  assign err_unknown_req   = err_q;

endmodule

// File: doc/hamming_batch_engine.md
HAMMING_BATCH_ENGINE -- requirements
Module: hamming_batch_engine

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning the sweep operand width in bits; legal range 4..16.
REQ-002 SHALL have parameter MAX_RESULTS, default 64, meaning the number of distances per sweep; legal range 1..510.
REQ-003 SHALL have port clk_50, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have port usb_configured, input, 1, USB device configured.
REQ-006 SHALL have port buf_in_ready, input, 1, IN buffer free (ULPI domain, unsynchronised).
REQ-007 SHALL have port buf_in_commit_ack, input, 1, commit acknowledge (ULPI domain).
REQ-008 SHALL have port vend_req_act, input, 1, vendor request active (ULPI domain).
REQ-009 SHALL have port vend_req_request, input, 8, vendor request code.
REQ-010 SHALL have port vend_req_val, input, 16, vendor request wValue.
REQ-011 SHALL have ports buf_in_addr (output, 9), buf_in_data (output, 8), buf_in_wren (output, 1), which form the IN buffer write port.
REQ-012 SHALL have ports buf_in_commit (output, 1) and buf_in_commit_len (output, 10), which form the IN buffer commit request.
REQ-013 SHALL have ports busy (output, 1, request in progress) and err_unknown_req (output, 1, sticky).

Function
REQ-014 SHALL pass buf_in_ready, buf_in_commit_ack and vend_req_act each through a 2-flop synchroniser; request start is a synchronised 0->1 edge of vend_req_act.
REQ-015 SHALL accept a start only in IDLE with usb_configured=1 and synchronised buf_in_ready=1; edges at any other time are dropped, not queued.
REQ-016 SHALL decode code 0x01 SINGLE: distance = popcount(val[15:8] XOR val[7:0]); write it at addr 0; commit len 1.
REQ-017 SHALL decode code 0x02 SET_PATTERN: pattern register <= val[WORD_W-1:0]; no write and no commit; return to IDLE next cycle.
REQ-018 SHALL decode code 0x03 SWEEP: candidate i = (val[WORD_W-1:0] + i) mod 2^WORD_W for i = 0..MAX_RESULTS-1; byte i = popcount(candidate XOR pattern), zero-extended to 8 bits, written at addr i; commit len MAX_RESULTS.
REQ-019 SHALL, on any other code, set err_unknown_req (stays set until reset), issue no write and no commit, and return to IDLE.
REQ-020 SHALL use states IDLE -> DECODE -> CALC -> WRITE -> COMMIT -> ACK_LOW -> IDLE; SET_PATTERN and unknown codes go DECODE -> IDLE.
REQ-021 SHALL register the popcount, so the first result is valid 1 cycle after its operands are applied.
REQ-022 SHALL, in SWEEP, pipeline one write per clock with wren high for exactly MAX_RESULTS consecutive cycles and addr incrementing from 0.
REQ-023 SHALL, in COMMIT, hold buf_in_commit=1 with a stable len until synchronised ack=1, then deassert commit and wait in ACK_LOW until synchronised ack=0.
REQ-024 SHALL drive busy=1 in every state except IDLE.
REQ-025 SHALL wrap the candidate index modulo 2^WORD_W, e.g. start 0xFF, WORD_W=8 gives 0xFF, 0x00, 0x01, ...
REQ-026 SHALL, when a start edge and reset coincide, give reset priority.

Reset
REQ-027 SHALL, on reset, set state=IDLE, clear pattern and the synchronisers, and drive all outputs 0 (addr, data, wren, commit, len, busy, err) on the next edge.
REQ-028 SHALL, if reset is asserted mid-sweep or mid-commit, abandon the request without completing the commit.

Configuration
REQ-029 SHALL, with macro HAMMING_MIN_TRACK_EN defined, track the minimum distance over a SWEEP (first index wins ties).
REQ-030 SHALL, with HAMMING_MIN_TRACK_EN defined, append the minimum distance at addr MAX_RESULTS and its index[7:0] at addr MAX_RESULTS+1, making commit len MAX_RESULTS+2.
REQ-031 SHALL, with HAMMING_MIN_TRACK_EN defined, leave SINGLE behaviour unchanged.
REQ-032 SHALL, without HAMMING_MIN_TRACK_EN, contain no min-tracking logic.

Verification
REQ-033 SHALL cover SINGLE: code 0x01 with val 0xF0_0F -> byte 0x08 written at addr 0; commit len 1; busy returns to 0 after ack falls.
REQ-034 SHALL cover SWEEP: pattern 0x00 then code 0x03 with val 0x0000, MAX_RESULTS=4 -> bytes 0,1,1,2 at addr 0..3; len 4.
REQ-035 SHALL cover wrap: pattern 0xFF, sweep start 0xFE, MAX_RESULTS=4 -> candidates FE, FF, 00, 01 -> bytes 1,0,8,7.
REQ-036 SHALL cover an unknown code 0x7E -> err_unknown_req=1 with no wren and no commit; a second start edge during a SWEEP is ignored.
REQ-037 SHALL cover reset asserted on the 2nd WRITE cycle -> all outputs 0 next cycle; a following SINGLE completes normally.
REQ-038 SHALL cover, with HAMMING_MIN_TRACK_EN defined and the REQ-034 stimulus -> extra bytes 0x00, 0x00 at addr 4..5; len 6.
